// File: rtl/alu_pkg.sv
// Shared encodings and widths for the sequential ALU controller and its datapath core.
package alu_pkg;

   localparam int unsigned DataW = 32;
   localparam int unsigned CntW  = 5;

   typedef enum logic [3:0] {
      OpAdd = 4'd0,
      OpSub = 4'd1,
      OpAnd = 4'd2,
      OpOr  = 4'd3,
      OpXor = 4'd4,
      OpNot = 4'd5,
      OpSla = 4'd6,
      OpSra = 4'd7,
      OpSrl = 4'd8
   } alu_op_e;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } state_e;

   function automatic logic is_shift(logic [3:0] op);
      return (op == OpSla) || (op == OpSra) || (op == OpSrl);
   endfunction

   function automatic logic is_legal(logic [3:0] op);
      return op <= OpSrl;
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU step: one arith/logic op or one 1-bit shift with carry-out.
// With ALU_SEQ_FAST_SHIFT_EN defined, shifts use a full barrel shift by b_i[4:0].
module alu_core import alu_pkg::*; (
   input  logic [3:0]       op_i,
   input  logic [DataW-1:0] a_i,
   input  logic [DataW-1:0] b_i,
   output logic [DataW-1:0] res_o,
   output logic             carry_o
);

   logic [DataW:0] sum;
`ifdef ALU_SEQ_FAST_SHIFT_EN
   logic [DataW:0]   ext;
   logic [CntW-1:0]  shamt;

   assign shamt = b_i[CntW-1:0];
`endif

   always_comb begin
      sum     = '0;
      res_o   = '0;
      carry_o = 1'b0;
`ifdef ALU_SEQ_FAST_SHIFT_EN
      ext     = '0;
`endif
      case (op_i)
         OpAdd: begin
            sum     = {1'b0, a_i} + {1'b0, b_i};
            res_o   = sum[DataW-1:0];
            carry_o = sum[DataW];
         end
         OpSub: begin
            sum     = {1'b0, a_i} + {1'b0, ~b_i} + {{DataW{1'b0}}, 1'b1};
            res_o   = sum[DataW-1:0];
            carry_o = sum[DataW];
         end
         OpAnd: res_o = a_i & b_i;
         OpOr:  res_o = a_i | b_i;
         OpXor: res_o = a_i ^ b_i;
         OpNot: res_o = ~a_i;
`ifdef ALU_SEQ_FAST_SHIFT_EN
         // Extra bit beside the word catches the last bit shifted out.
         OpSla: begin
            ext     = {1'b0, a_i} << shamt;
            res_o   = ext[DataW-1:0];
            carry_o = ext[DataW];
         end
         OpSra: begin
            ext     = $signed({a_i, 1'b0}) >>> shamt;
            res_o   = ext[DataW:1];
            carry_o = ext[0];
         end
         OpSrl: begin
            ext     = {a_i, 1'b0} >> shamt;
            res_o   = ext[DataW:1];
            carry_o = ext[0];
         end
`else
         OpSla: begin
            res_o   = {a_i[DataW-2:0], 1'b0};
            carry_o = a_i[DataW-1];
         end
         OpSra: begin
            res_o   = {a_i[DataW-1], a_i[DataW-1:1]};
            carry_o = a_i[0];
         end
         OpSrl: begin
            res_o   = {1'b0, a_i[DataW-1:1]};
            carry_o = a_i[0];
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequential ALU controller: valid/ready request, iterative shifter FSM, held response.
// Define ALU_SEQ_FAST_SHIFT_EN to replace iterative shifting with a single-cycle barrel shift.
module alu_seq_ctrl import alu_pkg::*; (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [DataW-1:0] operandA,
   input  logic [DataW-1:0] operandB,
   input  logic [3:0]       aluOp,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [DataW-1:0] res,
   output logic             zeroFlag,
   output logic             carryFlag,
   output logic             errFlag
);

   state_e           state_q, state_d;
   logic [DataW-1:0] res_q, res_d;
   logic             zero_q, zero_d;
   logic             carry_q, carry_d;
   logic             err_q, err_d;
   logic [3:0]       op_q, op_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [CntW-1:0]  req_cnt;
   logic             accept, start_shift, in_shift;
   logic [3:0]       core_op;
   logic [DataW-1:0] core_a, core_res;
   logic             core_carry;

   assign req_cnt  = operandB[CntW-1:0];
   assign accept   = req_valid && (state_q == StIdle);
   assign in_shift = (state_q == StShift);

`ifdef ALU_SEQ_FAST_SHIFT_EN
   assign start_shift = 1'b0;
`else
   // The accept cycle already performs the first 1-bit step, so only counts >= 2 iterate.
   assign start_shift = is_shift(aluOp) && (req_cnt > CntW'(1));
`endif

   assign core_op = in_shift ? op_q  : aluOp;
   assign core_a  = in_shift ? res_q : operandA;

   alu_core u_core (
      .op_i    (core_op),
      .a_i     (core_a),
      .b_i     (operandB),
      .res_o   (core_res),
      .carry_o (core_carry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (accept) state_d = start_shift ? StShift : StDone;
         StShift: if (cnt_q == CntW'(1)) state_d = StDone;
         StDone:  if (rsp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      req_ready = (state_q == StIdle);
      rsp_valid = (state_q == StDone);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q   <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         err_q   <= 1'b0;
         op_q    <= '0;
         cnt_q   <= '0;
      end else begin
         res_q   <= res_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
         err_q   <= err_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      res_d   = res_q;
      zero_d  = zero_q;
      carry_d = carry_q;
      err_d   = err_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      if (accept) begin
         op_d  = aluOp;
         err_d = 1'b0;
         cnt_d = '0;
         if (!is_legal(aluOp)) begin
            res_d   = '0;
            zero_d  = 1'b1;
            carry_d = 1'b0;
            err_d   = 1'b1;
         end else if (is_shift(aluOp) && (req_cnt == '0)) begin
            res_d   = operandA;
            zero_d  = (operandA == '0);
            carry_d = 1'b0;
         end else begin
            res_d   = core_res;
            zero_d  = (core_res == '0);
            carry_d = core_carry;
            if (start_shift) cnt_d = req_cnt - CntW'(1);
         end
      end else if (in_shift) begin
         res_d   = core_res;
         zero_d  = (core_res == '0);
         carry_d = core_carry;
         cnt_d   = cnt_q - CntW'(1);
      end
   end

   assign res       = res_q;
   assign zeroFlag  = zero_q;
   assign carryFlag = carry_q;
   assign errFlag   = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed vector table, reset-abort sequence and
// random operations checked against a plain-arithmetic reference model.
module tb_alu_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, rsp_valid, rsp_ready;
   logic [31:0] operandA, operandB, res;
   logic [3:0]  aluOp;
   logic        zeroFlag, carryFlag, errFlag;

   int errors = 0;
   int checks = 0;

`ifdef ALU_SEQ_FAST_SHIFT_EN
   localparam bit Fast = 1'b1;
`else
   localparam bit Fast = 1'b0;
`endif

   alu_seq_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .operandA  (operandA),
      .operandB  (operandB),
      .aluOp     (aluOp),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .res       (res),
      .zeroFlag  (zeroFlag),
      .carryFlag (carryFlag),
      .errFlag   (errFlag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          hold;
      logic [31:0] r;
      logic        z;
      logic        c;
      logic        e;
      int          lat;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Reference: latency = cycles from accept edge until rsp_valid is seen (1 = next cycle).
   function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic z, output logic c,
                                 output logic e, output int lat);
      longint unsigned s;
      logic [63:0]     w;
      int              n;
      n   = int'(b[4:0]);
      r   = '0;
      c   = 1'b0;
      e   = 1'b0;
      lat = 1;
      case (op)
         4'd0: begin s = longint'(a) + longint'(b); r = a + b; c = (s > 64'hFFFF_FFFF); end
         4'd1: begin r = a - b; c = (a >= b); end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = ~a;
         4'd6: begin w = {32'd0, a} << n; r = w[31:0]; c = w[32]; end
         4'd7: begin w = {a, 32'd0}; w = $signed(w) >>> n; r = w[63:32]; c = w[31]; end
         4'd8: begin w = {a, 32'd0} >> n; r = w[63:32]; c = w[31]; end
         default: e = 1'b1;
      endcase
      if (op >= 4'd6 && op <= 4'd8 && n > 1 && !Fast) lat = n;
      z = (r == 0);
   endfunction

   task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input logic [31:0] r, input logic z, input logic c,
                        input logic e, input int lat, input string nm);
      int got_lat;
      @(negedge clk);
      chk({nm, " req_ready idle"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      aluOp     = op;
      operandA  = a;
      operandB  = b;
      @(posedge clk);
      #1;
      // Junk traffic while busy must be ignored.
      req_valid = 1'($urandom_range(0, 1));
      aluOp     = 4'($urandom);
      operandA  = $urandom;
      operandB  = $urandom;
      got_lat   = 1;
      while (!rsp_valid && got_lat < 40) begin
         @(posedge clk);
         #1;
         got_lat++;
      end
      chk({nm, " latency"}, 32'(got_lat), 32'(lat));
      chk({nm, " res"}, res, r);
      chk({nm, " flags zce"}, {29'd0, zeroFlag, carryFlag, errFlag}, {29'd0, z, c, e});
      chk({nm, " req_ready busy"}, 32'(req_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1;
         @(posedge clk);
         #1;
         chk({nm, " held res"}, res, r);
         chk({nm, " held valid/ready"}, {30'd0, rsp_valid, req_ready}, 32'b10);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk({nm, " after handshake"}, {30'd0, rsp_valid, req_ready}, 32'b01);
   endtask

   initial begin
      logic [31:0] r, a, b;
      logic [3:0]  op;
      logic        z, c, e;
      int          lat, seen;

      vecs[0]  = '{4'd0, 32'd30, 32'd10, 0, 32'd40, 1'b0, 1'b0, 1'b0, 1};
      vecs[1]  = '{4'd1, 32'd10, 32'd10, 0, 32'd0, 1'b1, 1'b1, 1'b0, 1};
      vecs[2]  = '{4'd0, 32'hFFFF_FFFF, 32'd1, 0, 32'd0, 1'b1, 1'b1, 1'b0, 1};
      vecs[3]  = '{4'd7, 32'hFFFF_FFFE, 32'd3, 0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, Fast ? 1 : 3};
      vecs[4]  = '{4'd6, 32'd7, 32'd1, 0, 32'd14, 1'b0, 1'b0, 1'b0, 1};
      vecs[5]  = '{4'd4, 32'd14, 32'd3, 5, 32'd13, 1'b0, 1'b0, 1'b0, 1};
      vecs[6]  = '{4'hF, 32'd5, 32'd5, 0, 32'd0, 1'b1, 1'b0, 1'b1, 1};
      vecs[7]  = '{4'd1, 32'd5, 32'd7, 0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1};
      vecs[8]  = '{4'd8, 32'h8000_0000, 32'd31, 1, 32'd1, 1'b0, 1'b0, 1'b0, Fast ? 1 : 31};
      vecs[9]  = '{4'd6, 32'h8000_0001, 32'd0, 0, 32'h8000_0001, 1'b0, 1'b0, 1'b0, 1};
      vecs[10] = '{4'd5, 32'hFFFF_FFFF, 32'd9, 0, 32'd0, 1'b1, 1'b0, 1'b0, 1};
      vecs[11] = '{4'd2, 32'h0000_F0F0, 32'h0000_FF00, 0, 32'h0000_F000, 1'b0, 1'b0, 1'b0, 1};
      vecs[12] = '{4'd3, 32'd0, 32'd0, 2, 32'd0, 1'b1, 1'b0, 1'b0, 1};
      vecs[13] = '{4'd6, 32'h4000_0000, 32'd2, 0, 32'd0, 1'b1, 1'b1, 1'b0, Fast ? 1 : 2};

      rst_n     = 1'b0;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      aluOp     = '0;
      operandA  = '0;
      operandB  = '0;
      #1;
      chk("reset outputs", {res, 1'b0}, 33'd0);
      chk("reset ctrl/flags", {27'd0, req_ready, rsp_valid, zeroFlag, carryFlag, errFlag},
          32'b10000);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i])
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].r, vecs[i].z,
               vecs[i].c, vecs[i].e, vecs[i].lat, $sformatf("vec%0d", i));

      // Reset four cycles into a long shift abandons it.
      @(negedge clk);
      aluOp     = 4'd8;
      operandA  = 32'h8000_0000;
      operandB  = 32'd31;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort res", res, 32'd0);
      chk("abort ctrl/flags", {27'd0, req_ready, rsp_valid, zeroFlag, carryFlag, errFlag},
          32'b10000);
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (rsp_valid) seen++;
      end
      chk("abort no response", 32'(seen), 32'd0);
      do_op(4'd0, 32'd100, 32'd23, 0, 32'd123, 1'b0, 1'b0, 1'b0, 1, "post-abort add");

      for (int i = 0; i < 60; i++) begin
         op = 4'($urandom_range(0, 11));
         a  = (i % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
         b  = (i % 5 == 0) ? a : $urandom;
         model(op, a, b, r, z, c, e, lat);
         do_op(op, a, b, int'($urandom_range(0, 3)), r, z, c, e, lat,
               $sformatf("rand%0d op%0d", i, op));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL: req_valid  input  1  initiator presents an operation.
REQ-004 SHALL: req_ready  output  1  block can accept an operation.
REQ-005 SHALL: operandA, operandB  input  32 each  operands; operandB[4:0] is the shift count for shift ops.
REQ-006 SHALL: aluOp  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(A), 6 SLA, 7 SRA, 8 SRL, 9-15 illegal.
REQ-007 SHALL: rsp_valid  output  1  result available; rsp_ready  input  1  consumer takes it.
REQ-008 SHALL: res  output  32, zeroFlag  output  1, carryFlag  output  1, errFlag  output  1  response payload, stable while rsp_valid=1.

Function
REQ-009 SHALL: states IDLE, SHIFT, DONE; req_ready=1 only in IDLE; rsp_valid=1 only in DONE.
REQ-010 SHALL: capture operands and aluOp on the edge where req_valid&&req_ready.
REQ-011 SHALL: non-shift ops, and shifts with count 0, go IDLE->DONE; rsp_valid rises 1 cycle after the accept edge.
REQ-012 SHALL: shifts with count N=1..31 go IDLE->SHIFT, perform one 1-bit shift per cycle, enter DONE after N shift cycles; rsp_valid rises N cycles after the accept edge.
REQ-013 SHALL: SLA and SRL fill vacated bits with 0; SRA replicates bit 31.
REQ-014 SHALL: ADD carryFlag = bit 32 of the 33-bit sum; SUB computes A+~B+1, carryFlag = bit 32 (1 = no borrow).
REQ-015 SHALL: for shifts, carryFlag = last bit shifted out (0 if count 0); for logic ops, carryFlag = 0.
REQ-016 SHALL: zeroFlag = (res==0), evaluated on the final result.
REQ-017 SHALL: illegal aluOp completes with 1-cycle latency, res=0, zeroFlag=1, carryFlag=0, errFlag=1; errFlag=0 for all legal ops.
REQ-018 SHALL: DONE->IDLE on the edge where rsp_ready=1; payload and rsp_valid held unchanged while rsp_ready=0.
REQ-019 SHALL: req_valid, operand and aluOp changes outside IDLE are ignored; no request is queued.
REQ-020 SHALL: shift counter wraps never; counter width 5 bits, decremented to 0 exactly.

Reset
REQ-021 SHALL: on rst_n=0, immediately return to IDLE with req_ready=1, rsp_valid=0, res=0, zeroFlag=0, carryFlag=0, errFlag=0, counter=0.
REQ-022 SHALL: reset during SHIFT or DONE abandon the operation; no response is ever produced for it.

Configuration
REQ-023 SHALL: macro ALU_SEQ_FAST_SHIFT_EN defined -> shifts use a 32-bit barrel shifter, SHIFT state unused, all ops 1-cycle latency, flags identical to REQ-013..016.
REQ-024 SHALL: macro undefined -> iterative shifting per REQ-012; no barrel shifter synthesized.

Structure
REQ-025 SHALL: package alu_pkg holds aluOp encodings, state encoding, data width 32 and shift-count width 5.
REQ-026 SHALL: one combinational sub-module alu_core computes a single step (arith/logic op or 1-bit shift) with result and carry-out; alu_seq_ctrl holds all registers and the FSM.

Verification
REQ-027 SHALL: ADD A=30 B=10, rsp_ready=1 -> res=40, zeroFlag=0, carryFlag=0, rsp_valid 1 cycle after accept.
REQ-028 SHALL: SUB A=10 B=10 -> res=0, zeroFlag=1, carryFlag=1; ADD A=0xFFFFFFFF B=1 -> res=0, carryFlag=1.
REQ-029 SHALL: SRA A=0xFFFFFFFE B=3 -> res=0xFFFFFFFF, carryFlag=1, rsp_valid 3 cycles after accept (1 with ALU_SEQ_FAST_SHIFT_EN); SLA A=7 B=1 -> res=14.
REQ-030 SHALL: XOR A=14 B=3 with rsp_ready=0 for 5 cycles -> res=13 held, rsp_valid=1, req_ready=0 throughout; second req_valid ignored until handshake.
REQ-031 SHALL: SRL A=0x80000000 B=31, rst_n low 4 cycles after accept -> rsp_valid=0, req_ready=1, all outputs 0; next op completes normally.
REQ-032 SHALL: aluOp=4'hF A=5 B=5 -> res=0, zeroFlag=1, errFlag=1, 1-cycle latency.
